// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: sweeps an MxNxK tiled matmul, issuing one core run per tile
// with incrementally generated A/B/C tile addresses and a sticky done register.
module matmul_tile_sequencer #(
    parameter int ADDR_W   = 11,
    parameter int STRIDE_W = 8,
    parameter int TILE     = 4,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_reg,
    input  logic                 clear_done_reg,
    input  logic                 accum_mode,
    input  logic [ADDR_W-1:0]    base_a,
    input  logic [ADDR_W-1:0]    base_b,
    input  logic [ADDR_W-1:0]    base_c,
    input  logic [STRIDE_W-1:0]  stride_a,
    input  logic [STRIDE_W-1:0]  stride_b,
    input  logic [STRIDE_W-1:0]  stride_c,
    input  logic [CNT_W-1:0]     m_tiles,
    input  logic [CNT_W-1:0]     n_tiles,
    input  logic [CNT_W-1:0]     k_tiles,
    input  logic                 core_done,
    output logic                 core_start,
    output logic                 core_clear_done,
    output logic [ADDR_W-1:0]    core_addr_a,
    output logic [ADDR_W-1:0]    core_addr_b,
    output logic [ADDR_W-1:0]    core_addr_c,
    output logic                 core_accum,
    output logic                 core_store,
    output logic                 busy,
    output logic                 done_reg,
    output logic [3*CNT_W-1:0]   tile_count
);
    localparam int TS = $clog2(TILE);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, RELEASE, NEXT, DONE} state_t;

    state_t              state_q, state_d;
    logic                start_q, start_d, armed_q, armed_d, accum_q, accum_d;
    logic [CNT_W-1:0]    keff_q, keff_d, m_q, m_d, n_q, n_d;
    logic [CNT_W-1:0]    mi_q, mi_d, ni_q, ni_d, ki_q, ki_d;
    logic [STRIDE_W-1:0] sa_q, sa_d, sb_q, sb_d, sc_q, sc_d;
    logic [ADDR_W-1:0]   base_a_q, base_a_d;
    logic [ADDR_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [ADDR_W-1:0]   a_row_q, a_row_d, b_col_q, b_col_d, c_col_q, c_col_d;
    logic [3*CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]   step_a, step_b, step_c, tile_step;
    logic [CNT_W-1:0]    keff_in;

    assign step_a    = ADDR_W'(sa_q) << TS;
    assign step_b    = ADDR_W'(sb_q) << TS;
    assign step_c    = ADDR_W'(sc_q) << TS;
    assign tile_step = ADDR_W'(TILE);
    assign keff_in   = accum_mode ? k_tiles : CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            armed_q  <= 1'b0;
            accum_q  <= 1'b0;
            keff_q   <= '0;
            m_q      <= '0;
            n_q      <= '0;
            mi_q     <= '0;
            ni_q     <= '0;
            ki_q     <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            sc_q     <= '0;
            base_a_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            a_row_q  <= '0;
            b_col_q  <= '0;
            c_col_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            armed_q  <= armed_d;
            accum_q  <= accum_d;
            keff_q   <= keff_d;
            m_q      <= m_d;
            n_q      <= n_d;
            mi_q     <= mi_d;
            ni_q     <= ni_d;
            ki_q     <= ki_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sc_q     <= sc_d;
            base_a_q <= base_a_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            a_row_q  <= a_row_d;
            b_col_q  <= b_col_d;
            c_col_q  <= c_col_d;
            cnt_q    <= cnt_d;
        end
    end

    // armed_q requires start_reg to be seen low after reset, so a level held through reset never triggers
    always_comb begin
        state_d  = state_q;
        start_d  = start_reg;
        armed_d  = armed_q | ~start_reg;
        accum_d  = accum_q;
        keff_d   = keff_q;
        m_d      = m_q;
        n_d      = n_q;
        mi_d     = mi_q;
        ni_d     = ni_q;
        ki_d     = ki_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sc_d     = sc_q;
        base_a_d = base_a_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        a_row_d  = a_row_q;
        b_col_d  = b_col_q;
        c_col_d  = c_col_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: state_d = (start_reg & ~start_q & armed_q) ? LOAD : IDLE;
            LOAD: begin
                accum_d  = accum_mode;
                keff_d   = keff_in;
                m_d      = m_tiles;
                n_d      = n_tiles;
                mi_d     = '0;
                ni_d     = '0;
                ki_d     = '0;
                sa_d     = stride_a;
                sb_d     = stride_b;
                sc_d     = stride_c;
                base_a_d = base_a;
                a_d      = base_a;
                a_row_d  = base_a;
                b_d      = base_b;
                b_col_d  = base_b;
                c_d      = base_c;
                c_col_d  = base_c;
                cnt_d    = '0;
                state_d  = (m_tiles == '0 || n_tiles == '0 || keff_in == '0) ? DONE : RUN;
            end
            RUN: state_d = core_done ? RELEASE : RUN;
            RELEASE: begin
                state_d = core_done ? RELEASE : NEXT;
                cnt_d   = core_done ? cnt_q : cnt_q + 1'b1;
            end
            NEXT: begin
                state_d = RUN;
                if (ki_q != keff_q - 1'b1) begin
                    ki_d = ki_q + 1'b1;
                    a_d  = a_q + step_a;
                    b_d  = b_q + tile_step;
                end else begin
                    ki_d = '0;
                    if (mi_q != m_q - 1'b1) begin
                        mi_d    = mi_q + 1'b1;
                        a_row_d = a_row_q + tile_step;
                        a_d     = a_row_q + tile_step;
                        b_d     = b_col_q;
                        c_d     = c_q + tile_step;
                    end else begin
                        mi_d    = '0;
                        a_row_d = base_a_q;
                        a_d     = base_a_q;
                        if (ni_q != n_q - 1'b1) begin
                            ni_d    = ni_q + 1'b1;
                            b_col_d = b_col_q + step_b;
                            b_d     = b_col_q + step_b;
                            c_col_d = c_col_q + step_c;
                            c_d     = c_col_q + step_c;
                        end else begin
                            ni_d    = '0;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: state_d = clear_done_reg ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign core_start      = state_q == RUN;
    assign core_clear_done = state_q == RELEASE;
    assign core_accum      = core_start & accum_q & (ki_q != '0);
    assign core_store      = core_start & (ki_q == keff_q - 1'b1);
    assign busy            = state_q != IDLE && state_q != DONE;
    assign done_reg        = state_q == DONE;
    assign core_addr_a     = a_q;
    assign core_addr_b     = b_q;
    assign core_addr_c     = c_q;
    assign tile_count      = cnt_q;
endmodule
